// File: rtl/mem_stage.sv
// Memory stage: passes ALU results through to writeback and runs a
// single outstanding word load/store on the data-memory port.
module mem_stage #(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [31:0]       result_in,
  input  logic [4:0]        write_reg_in,
  input  logic              reg_write_in,
  input  logic              writef_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic [31:0]       mem_write_data_in,
  input  logic [31:0]       pc_in,
  input  logic              wait_exec_in,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata,
  output logic [31:0]       result_out,
  output logic [4:0]        write_reg_out,
  output logic              reg_write_out,
  output logic              writef_out,
  output logic [31:0]       pc_out,
  output logic              wait_mem_out
);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t state_q, state_d;

  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic [31:0] result_q, result_d;
  logic [4:0]  wreg_q, wreg_d;
  logic        rw_q, rw_d;
  logic        wf_q, wf_d;
  logic [31:0] pc_q, pc_d;

  logic mem_op;
  logic unused_bits;

  // Byte offset and bits above the memory window are ignored.
  assign unused_bits = ^{result_in[1:0], result_in[31:ADDR_W+2]};

  assign mem_op = (mem_read_in | mem_write_in) & ~wait_exec_in;

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    result_d     = result_q;
    wreg_d       = wreg_q;
    rw_d         = rw_q;
    wf_d         = wf_q;
    pc_d         = pc_q;
    wait_mem_out = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_op) begin
          wait_mem_out = 1'b1;
          state_d      = BUSY;
          addr_d       = result_in[ADDR_W+1:2];
          wdata_d      = mem_write_data_in;
          we_d         = mem_write_in;
          rw_d         = 1'b0;
          wreg_d       = 5'd0;
        end else if (wait_exec_in) begin
          rw_d   = 1'b0;
          wreg_d = 5'd0;
        end else begin
          result_d = result_in;
          wreg_d   = write_reg_in;
          rw_d     = reg_write_in;
          wf_d     = writef_in;
          pc_d     = pc_in;
        end
      end
      BUSY: begin
        wait_mem_out = ~dmem_ack;
        if (dmem_ack) begin
          state_d  = IDLE;
          result_d = we_q ? result_in : dmem_rdata;
          wreg_d   = write_reg_in;
          rw_d     = reg_write_in;
          wf_d     = writef_in;
          pc_d     = pc_in;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      result_q <= '0;
      wreg_q   <= '0;
      rw_q     <= 1'b0;
      wf_q     <= 1'b0;
      pc_q     <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      result_q <= result_d;
      wreg_q   <= wreg_d;
      rw_q     <= rw_d;
      wf_q     <= wf_d;
      pc_q     <= pc_d;
    end
  end

  assign dmem_req      = (state_q == BUSY);
  assign dmem_we       = we_q;
  assign dmem_addr     = addr_q;
  assign dmem_wdata    = wdata_q;
  assign result_out    = result_q;
  assign write_reg_out = wreg_q;
  assign reg_write_out = rw_q;
  assign writef_out    = wf_q;
  assign pc_out        = pc_q;

endmodule
